// File: rtl/text_pkg.sv
// Shared definitions for the text-mode renderer.
// Provides the text grid geometry, the 12-bit RGB pixel type, sync polarity
// and default colours, plus the cell-address helper used by the renderer.
package text_pkg;

    localparam int unsigned COLS   = 80;   // 640 / CELL_W
    localparam int unsigned ROWS   = 60;   // 480 / CELL_W
    localparam int unsigned CELL_W = 8;
    localparam int unsigned ADDR_W = 13;   // covers COLS * ROWS = 4800 cells

    typedef logic [11:0] rgb12_t;          // {R[3:0], G[3:0], B[3:0]}

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = ~SYNC_ACTIVE;

    localparam rgb12_t DEFAULT_FG = 12'hFFF;
    localparam rgb12_t DEFAULT_BG = 12'h000;

    // row * 80 + col built from shifts (row*64 + row*16); no multiplier.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] row,
                                                    input logic [6:0] col);
        logic [ADDR_W-1:0] r;
        r = {6'b0, row};
        return (r << 6) + (r << 4) + {6'b0, col};
    endfunction

endpackage

// File: rtl/text_blink_timer.sv
// Cursor blink timer.
// Counts frames on the falling (idle -> active) edge of vsync and toggles the
// blink phase every BLINK_FRAMES frames.
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   vsync_in     raw vertical sync, active-low
//   blink_state  current blink phase, 0 after reset
module text_blink_timer
    import text_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    output logic blink_state
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             vsync_prev;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frame_cnt_next;
    logic             blink_next;
    logic             frame_start;

    assign frame_start = (vsync_prev == SYNC_IDLE) && (vsync_in == SYNC_ACTIVE);

    always_comb begin
        frame_cnt_next = frame_cnt;
        blink_next     = blink_state;
        if (frame_start) begin
            // The edge that lands on the last count wraps and toggles once.
            if (frame_cnt == CNT_LAST) begin
                frame_cnt_next = '0;
                blink_next     = ~blink_state;
            end else begin
                frame_cnt_next = frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev  <= SYNC_IDLE;
            frame_cnt   <= '0;
            blink_state <= 1'b0;
        end else begin
            vsync_prev  <= vsync_in;
            frame_cnt   <= frame_cnt_next;
            blink_state <= blink_next;
        end
    end

endmodule

// File: rtl/text_pixel_renderer.sv
// Text-mode pixel renderer: 8x8 character cells, one 12-bit pixel per clock.
// Pipeline: S0 registers the text RAM address and side signals, S1 is the
// RAM read cycle, S2 looks up the glyph row combinationally and registers rgb.
// Ports:
//   clk, rst                     pixel clock, synchronous active-high reset
//   pix_x, pix_y, video_on       current coordinate from the timing generator
//   hsync_in, vsync_in           raw syncs (active-low)
//   ram_addr / ram_data          text RAM, 1-cycle synchronous read
//   font_code, font_row          font ROM query (combinational)
//   font_pixels                  glyph row, bit 7 = leftmost pixel
//   cursor_col/row/en            cursor position and enable
//   rgb                          output pixel
//   hsync_out, vsync_out         syncs delayed 3 cycles to align with rgb
//   blink_state                  current cursor blink phase
module text_pixel_renderer
    import text_pkg::*;
#(
    parameter int unsigned COLS         = text_pkg::COLS,
    parameter int unsigned ROWS         = text_pkg::ROWS,
    parameter int unsigned ADDR_W       = text_pkg::ADDR_W,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter rgb12_t      FG_RGB       = DEFAULT_FG,
    parameter rgb12_t      BG_RGB       = DEFAULT_BG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic [7:0]        font_code,
    output logic [2:0]        font_row,
    input  logic [7:0]        font_pixels,
    input  logic [6:0]        cursor_col,
    input  logic [5:0]        cursor_row,
    input  logic              cursor_en,
    output rgb12_t            rgb,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blink_state
);

    // Stage 0 registers
    logic [2:0] s0_x_lo;
    logic [2:0] s0_y_lo;
    logic       s0_video_on;
    logic       s0_hsync;
    logic       s0_vsync;
    logic [6:0] s0_cell_col;
    logic [6:0] s0_cell_row;
    logic       s0_cursor_match;

    // Stage 1 registers
    logic [2:0] s1_x_lo;
    logic [2:0] s1_y_lo;
    logic       s1_video_on;
    logic       s1_hsync;
    logic       s1_vsync;
    logic       s1_cursor_match;

    logic [6:0]        cell_col;
    logic [6:0]        cell_row;
    logic              cursor_match;
    logic [ADDR_W-1:0] addr_next;
    logic              glyph_bit;
    logic              cursor_hit;
    rgb12_t            rgb_next;

    assign cell_col = pix_x[9:3];
    assign cell_row = pix_y[9:3];

    // Cursor is compared with the coordinate it belongs to, so a move is
    // applied on a pixel boundary. Out-of-range cursor positions never match.
    assign cursor_match = cursor_en
                        && (cursor_col < 7'(COLS))
                        && (cursor_row < 6'(ROWS))
                        && (cell_col == cursor_col)
                        && (cell_row == {1'b0, cursor_row});

    assign addr_next = video_on ? ADDR_W'(cell_addr(cell_row, cell_col)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr        <= '0;
            s0_x_lo         <= '0;
            s0_y_lo         <= '0;
            s0_video_on     <= 1'b0;
            s0_hsync        <= SYNC_IDLE;
            s0_vsync        <= SYNC_IDLE;
            s0_cell_col     <= '0;
            s0_cell_row     <= '0;
            s0_cursor_match <= 1'b0;
            s1_x_lo         <= '0;
            s1_y_lo         <= '0;
            s1_video_on     <= 1'b0;
            s1_hsync        <= SYNC_IDLE;
            s1_vsync        <= SYNC_IDLE;
            s1_cursor_match <= 1'b0;
            rgb             <= '0;
            hsync_out       <= SYNC_IDLE;
            vsync_out       <= SYNC_IDLE;
        end else begin
            ram_addr        <= addr_next;
            s0_x_lo         <= pix_x[2:0];
            s0_y_lo         <= pix_y[2:0];
            s0_video_on     <= video_on;
            s0_hsync        <= hsync_in;
            s0_vsync        <= vsync_in;
            s0_cell_col     <= cell_col;
            s0_cell_row     <= cell_row;
            s0_cursor_match <= cursor_match;
            s1_x_lo         <= s0_x_lo;
            s1_y_lo         <= s0_y_lo;
            s1_video_on     <= s0_video_on;
            s1_hsync        <= s0_hsync;
            s1_vsync        <= s0_vsync;
            s1_cursor_match <= s0_cursor_match;
            rgb             <= rgb_next;
            hsync_out       <= s1_hsync;
            vsync_out       <= s1_vsync;
        end
    end

    // Cell position is carried for debug visibility only; the match is
    // already resolved in stage 0.
    logic unused_cell;
    assign unused_cell = ^{s0_cell_col, s0_cell_row};

    // Stage 2: ram_data is valid this cycle, font ROM answers combinationally.
    assign font_code = ram_data;
    assign font_row  = s1_y_lo;

    always_comb begin
        rgb_next   = 12'h000;
        glyph_bit  = font_pixels[3'd7 - s1_x_lo];
        cursor_hit = s1_cursor_match & blink_state;
        if (s1_video_on) begin
            rgb_next = (glyph_bit ^ cursor_hit) ? FG_RGB : BG_RGB;
        end
    end

    text_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .rst         (rst),
        .vsync_in    (vsync_in),
        .blink_state (blink_state)
    );

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Bench for text_pixel_renderer with a text RAM model and a small font model.
module tb_text_pixel_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [12:0] ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  font_code;
    logic [2:0]  font_row;
    logic [7:0]  font_pixels;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        cursor_en;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        blink_state;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] ram [0:8191];

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        string       tag;
    } exp_t;

    exp_t q[$];

    text_pixel_renderer #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .video_on    (video_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .font_code   (font_code),
        .font_row    (font_row),
        .font_pixels (font_pixels),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .cursor_en   (cursor_en),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .blink_state (blink_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_data <= ram[ram_addr];

    // 'A' glyph; every other code renders blank.
    function automatic logic [7:0] glyph(input logic [7:0] code, input logic [2:0] row);
        logic [7:0] g;
        g = 8'h00;
        if (code == 8'h41) begin
            case (row)
                3'd0: g = 8'b00011000;
                3'd1: g = 8'b00100100;
                3'd2: g = 8'b01000010;
                3'd3: g = 8'b01111110;
                3'd4: g = 8'b01000010;
                3'd5: g = 8'b01000010;
                default: g = 8'b00000000;
            endcase
        end
        return g;
    endfunction

    assign font_pixels = glyph(font_code, font_row);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One pixel per clock; the entry driven three steps ago is compared now.
    task automatic step(input string tag, input int x, input int y, input logic von,
                        input logic hs, input logic vs, input logic [11:0] exp_rgb);
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() >= 3) begin
            e = q.pop_front();
            chk({e.tag, "_rgb"}, {4'h0, rgb}, {4'h0, e.rgb});
            chk({e.tag, "_hs"}, {15'h0, hsync_out}, {15'h0, e.hs});
            chk({e.tag, "_vs"}, {15'h0, vsync_out}, {15'h0, e.vs});
        end
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        q.push_back('{rgb: exp_rgb, hs: hs, vs: vs, tag: tag});
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step("idle", 0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
    endtask

    task automatic vs_pulse();
        step("vs_lo", 0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
        step("vs_lo", 0, 0, 1'b0, 1'b1, 1'b0, 12'h000);
        step("vs_hi", 0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
        step("vs_hi", 0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
    endtask

    task automatic render_cell(input string tag, input int col, input logic [11:0] exp);
        for (int i = 0; i < 8; i++) step(tag, col * 8 + i, 3, 1'b1, 1'b1, 1'b1, exp);
        blank(3);
    endtask

    logic [11:0] glyph_exp [8] = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                                   12'hFFF, 12'h000, 12'h000, 12'h000};

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 8'h20;
        ram[0]     = 8'h41;
        rst        = 1'b1;
        pix_x      = '0;
        pix_y      = '0;
        video_on   = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        cursor_en  = 1'b0;
        cursor_col = '0;
        cursor_row = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", {4'h0, rgb}, 16'h0000);
        chk("rst_addr", {3'h0, ram_addr}, 16'd0);
        chk("rst_hs", {15'h0, hsync_out}, 16'd1);
        chk("rst_vs", {15'h0, vsync_out}, 16'd1);
        chk("rst_blink", {15'h0, blink_state}, 16'd0);
        rst = 1'b0;

        // Address generation, one edge of latency
        pix_x = 10'd17; pix_y = 10'd9; video_on = 1'b1;
        @(posedge clk); #1;
        chk("addr_17_9", {3'h0, ram_addr}, 16'd82);
        pix_x = 10'd639; pix_y = 10'd479;
        @(posedge clk); #1;
        chk("addr_last", {3'h0, ram_addr}, 16'd4799);
        video_on = 1'b0;
        @(posedge clk); #1;
        chk("addr_blank", {3'h0, ram_addr}, 16'd0);

        blank(3);

        // Glyph row 0 of 'A' in cell (0,0)
        for (int i = 0; i < 8; i++) step("glyph", i, 0, 1'b1, 1'b1, 1'b1, glyph_exp[i]);
        blank(3);

        // Blanking hides a set glyph pixel; hsync pulse delayed exactly 3
        step("blank_px", 3, 0, 1'b0, 1'b1, 1'b1, 12'h000);
        step("hs_pre", 0, 0, 1'b0, 1'b1, 1'b1, 12'h000);
        step("hs_pulse", 0, 0, 1'b0, 1'b0, 1'b1, 12'h000);
        blank(4);

        // Cursor blink with BLINK_FRAMES = 2
        ram[0]    = 8'h20;
        cursor_en = 1'b1;
        render_cell("cur_off0", 0, 12'h000);
        vs_pulse();
        chk("blink_after1", {15'h0, blink_state}, 16'd0);
        vs_pulse();
        chk("blink_after2", {15'h0, blink_state}, 16'd1);
        render_cell("cur_on", 0, 12'hFFF);
        render_cell("cur_other", 1, 12'h000);
        vs_pulse();
        vs_pulse();
        chk("blink_after4", {15'h0, blink_state}, 16'd0);
        render_cell("cur_off1", 0, 12'h000);

        // Cursor out of range never inverts; in-range column does
        vs_pulse();
        vs_pulse();
        chk("blink_oor", {15'h0, blink_state}, 16'd1);
        cursor_col = 7'd100;
        render_cell("oor_c0", 0, 12'h000);
        render_cell("oor_c1", 1, 12'h000);
        render_cell("oor_c79", 79, 12'h000);
        cursor_col = 7'd1;
        render_cell("inr_c0", 0, 12'h000);
        render_cell("inr_c1", 1, 12'hFFF);

        // Reset mid-stream
        cursor_en = 1'b0;
        ram[0]    = 8'h41;
        for (int i = 0; i < 4; i++) step("pre_rst", 3, 0, 1'b1, 1'b1, 1'b1, 12'hFFF);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_mid_rgb", {4'h0, rgb}, 16'h0000);
            chk("rst_mid_blink", {15'h0, blink_state}, 16'd0);
            @(posedge clk); #1;
        end
        chk("rst_resume", {4'h0, rgb}, 16'h0FFF);
        blank(3);
        for (int i = 0; i < 8; i++) step("glyph_post", i, 0, 1'b1, 1'b1, 1'b1, glyph_exp[i]);
        blank(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
